sd_cmd_sequencer: RTL and testbench

//  Command sequencer for spi_microSD. Runs SD v2 SPI-mode init after reset
//  (dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD58), then serves host

---
 rtl/sd_cmd_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: SD v2 SPI-mode init and single-block
// read/write command sequencer driving the spi_microSD core.
module sd_cmd_sequencer #(
  parameter int unsigned MAX_RETRY  = 8,
  parameter int unsigned ACMD41_MAX = 255,
  parameter logic [2:0]  INIT_DIV   = 3'b100,
  parameter logic [2:0]  FAST_DIV   = 3'b001
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        rd_req_i,
  input  logic        wr_req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        error_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        wr_data_ack_o,
  output logic [47:0] cmd_o,
  output logic [7:0]  status_o,
  output logic        enable_o,
  input  logic [2:0]  flag_i,
  input  logic [7:0]  r1_i,
  input  logic [31:0] core_data_i
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int AW = $clog2(ACMD41_MAX + 1);

  typedef enum logic [3:0] {
    S_PWRUP,
    S_CMD0,
    S_CMD8,
    S_CMD55,
    S_ACMD41,
    S_CMD58,
    S_READY,
    S_READ,
    S_WRITE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    P_LOAD,
    P_ISSUE,
    P_WAIT
  } phase_t;

  state_t        state;
  phase_t        phase;
  logic [RW-1:0] retry_cnt;
  logic [AW-1:0] acmd_cnt;
  logic [31:0]   addr_q;
  logic [1:0]    flag_q;
  logic          word_rise;
  logic          datawr_rise;
  logic          xfer;

  assign word_rise   = flag_i[0] & ~flag_q[0];
  assign datawr_rise = flag_i[2] & ~flag_q[1];
  assign xfer        = (phase != P_LOAD);

  assign ready_o = (state == S_READY);
  assign error_o = (state == S_ERROR);
  assign busy_o  = !ready_o && !error_o;

  function automatic logic [47:0] cmd_of(
    state_t s,
    logic [31:0] a
  );
    case (s)
      S_CMD0:   cmd_of = 48'h40_0000_0000_95;
      S_CMD8:   cmd_of = 48'h48_0000_01AA_87;
      S_CMD55:  cmd_of = 48'h77_0000_0000_65;
      S_ACMD41: cmd_of = 48'h69_4000_0000_77;
      S_CMD58:  cmd_of = 48'h7A_0000_0000_FD;
      S_READ:   cmd_of = {8'h51, a, 8'hFF};
      S_WRITE:  cmd_of = {8'h58, a, 8'hFF};
      default:  cmd_of = '1;
    endcase
  endfunction

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      state         <= S_PWRUP;
      phase         <= P_LOAD;
      retry_cnt     <= '0;
      acmd_cnt      <= '0;
      addr_q        <= '0;
      flag_q        <= '0;
      rd_data_o     <= '0;
      rd_valid_o    <= 1'b0;
      wr_data_ack_o <= 1'b0;
      cmd_o         <= '1;
      status_o      <= {INIT_DIV, 5'b00110};
      enable_o      <= 1'b0;
    end else begin
      flag_q        <= {flag_i[2], flag_i[0]};
      rd_valid_o    <= 1'b0;
      wr_data_ack_o <= 1'b0;
      case (state)
        S_READY: begin
          if (rd_req_i) begin
            state  <= S_READ;
            phase  <= P_LOAD;
            addr_q <= addr_i;
          end else if (wr_req_i) begin
            state  <= S_WRITE;
            phase  <= P_LOAD;
            addr_q <= addr_i;
          end
        end
        S_ERROR: begin
          status_o[0] <= 1'b0;
          enable_o    <= 1'b0;
        end
        default: begin
          case (phase)
            P_LOAD: begin
              cmd_o    <= cmd_of(state, addr_q);
              status_o <= {status_o[7:5],
                           state == S_READ,
                           state == S_WRITE,
                           1'b1,
                           state == S_PWRUP,
                           1'b1};
              enable_o <= 1'b1;
              phase    <= P_ISSUE;
            end
            P_ISSUE: begin
              if (!flag_i[1]) phase <= P_WAIT;
            end
            P_WAIT: begin
              if (flag_i[1]) begin
                status_o[0]   <= 1'b0;
                status_o[4:3] <= 2'b00;
                enable_o      <= 1'b0;
                phase         <= P_LOAD;
                // r1_i is sampled on the same edge the core reports done
                case (state)
                  S_PWRUP: state <= S_CMD0;
                  S_CMD0: begin
                    if (r1_i == 8'h01)
                      state <= S_CMD8;
                    else if (retry_cnt == RW'(MAX_RETRY - 1))
                      state <= S_ERROR;
                    else
                      retry_cnt <= retry_cnt + 1'b1;
                  end
                  S_CMD8: begin
                    if (r1_i == 8'h01) state <= S_CMD55;
                    else               state <= S_ERROR;
                  end
                  S_CMD55: begin
                    if (r1_i[7:1] == 7'd0) state <= S_ACMD41;
                    else                   state <= S_ERROR;
                  end
                  S_ACMD41: begin
                    if (r1_i == 8'h00)
                      state <= S_CMD58;
                    else if (r1_i == 8'h01 &&
                             acmd_cnt != AW'(ACMD41_MAX - 1)) begin
                      state    <= S_CMD55;
                      acmd_cnt <= acmd_cnt + 1'b1;
                    end else
                      state <= S_ERROR;
                  end
                  S_CMD58: begin
                    if (r1_i == 8'h00) begin
                      state         <= S_READY;
                      status_o[7:5] <= FAST_DIV;
                    end else
                      state <= S_ERROR;
                  end
                  default: begin
                    if (r1_i == 8'h00) state <= S_READY;
                    else               state <= S_ERROR;
                  end
                endcase
              end
            end
            default: phase <= P_LOAD;
          endcase
        end
      endcase
      // data movement overlaps the command's issue/wait phases
      if (state == S_READ && xfer && word_rise) begin
        rd_data_o  <= core_data_i;
        rd_valid_o <= 1'b1;
      end
      if (state == S_WRITE && xfer &&
          (word_rise || datawr_rise)) begin
        cmd_o         <= {wr_data_i, 16'hFFFF};
        wr_data_ack_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed bench with a behavioural SPI core
// model and scoreboards for commands, read words and write words.
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        ready;
  logic        busy;
  logic        error;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_ack;
  logic [47:0] cmd;
  logic [7:0]  status;
  logic        enable;
  logic [2:0]  flag;
  logic [7:0]  r1;
  logic [31:0] cdata;

  int checks = 0;
  int passed = 0;
  int rd_words = 128;
  int wr_words = 4;
  int rd_cnt = 0;
  int ack_cnt = 0;
  int issued = 0;

  logic [55:0] exp_cmd[$];
  logic [7:0]  r1_q[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_q[$];

  always #5 clk = ~clk;

  sd_cmd_sequencer dut (
    .spi_clk_i    (clk),
    .spi_rst_i    (rst),
    .rd_req_i     (rd_req),
    .wr_req_i     (wr_req),
    .addr_i       (addr),
    .wr_data_i    (wr_data),
    .ready_o      (ready),
    .busy_o       (busy),
    .error_o      (error),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .wr_data_ack_o(wr_ack),
    .cmd_o        (cmd),
    .status_o     (status),
    .enable_o     (enable),
    .flag_i       (flag),
    .r1_i         (r1),
    .core_data_i  (cdata)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_op(logic [7:0] st, logic [47:0] c,
                        logic [7:0] resp);
    exp_cmd.push_back({st, c});
    r1_q.push_back(resp);
  endtask

  task automatic push_init(int busy_cnt);
    exp_op(8'h87, 48'hFFFF_FFFF_FFFF, 8'hFF);
    exp_op(8'h85, 48'h40_0000_0000_95, 8'h01);
    exp_op(8'h85, 48'h48_0000_01AA_87, 8'h01);
    for (int i = 0; i <= busy_cnt; i++) begin
      exp_op(8'h85, 48'h77_0000_0000_65, 8'h01);
      exp_op(8'h85, 48'h69_4000_0000_77,
             (i == busy_cnt) ? 8'h00 : 8'h01);
    end
    exp_op(8'h85, 48'h7A_0000_0000_FD, 8'h00);
  endtask

  task automatic flush();
    exp_cmd.delete();
    r1_q.delete();
    exp_rd.delete();
    wr_q.delete();
  endtask

  task automatic wait_ready(string tag);
    int n = 0;
    while (!ready && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, ready, 1);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_wr_ack"}, wr_ack, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_cmd"}, cmd, 48'hFFFF_FFFF_FFFF);
    chk({tag, "_status"}, status, 8'h86);
    chk({tag, "_enable"}, enable, 0);
  endtask

  // behavioural core: handshake, data words, R1 from r1_q
  initial begin : core_model
    logic [55:0] e;
    logic [7:0]  st;
    flag  = 3'b010;
    r1    = 8'hFF;
    cdata = '0;
    wr_data = '0;
    forever begin
      tick();
      if (rst) begin
        flag = 3'b010;
      end else if (enable && status[0] && flag[1]) begin
        st = status;
        issued++;
        e = (exp_cmd.size() != 0) ? exp_cmd.pop_front()
                                  : 56'h0;
        chk("cmd", cmd, e[47:0]);
        chk("cmd_status", st, e[55:48]);
        tick();
        flag[1] = 1'b0;
        if (st[4]) begin
          for (int i = 0; i < rd_words && !rst; i++) begin
            tick();
            cdata = $urandom;
            exp_rd.push_back(cdata);
            flag[0] = 1'b1;
            tick();
            flag[0] = 1'b0;
            if (!rst) begin
              rd_cnt++;
              chk("rd_valid", rd_valid, 1);
              chk("rd_data", rd_data, exp_rd.pop_front());
            end
          end
        end
        if (st[3] && !rst) begin
          tick();
          wr_data = (wr_q.size() != 0) ? wr_q.pop_front()
                                       : $urandom;
          flag[2] = 1'b1;
          tick();
          flag[2] = 1'b0;
          if (!rst) begin
            ack_cnt++;
            chk("wr_ack", wr_ack, 1);
            chk("wr_cmd", cmd, {wr_data, 16'hFFFF});
          end
          for (int i = 0; i < wr_words && !rst; i++) begin
            tick();
            wr_data = $urandom;
            flag[0] = 1'b1;
            tick();
            flag[0] = 1'b0;
            if (!rst) begin
              ack_cnt++;
              chk("wr_word_ack", wr_ack, 1);
              chk("wr_word_cmd", cmd, {wr_data, 16'hFFFF});
            end
          end
        end
        tick();
        if (!rst) begin
          r1 = (r1_q.size() != 0) ? r1_q.pop_front() : 8'hFF;
          flag[1] = 1'b1;
        end
        tick();
      end
    end
  end

  initial begin : stimulus
    int n;
    int base;
    rst    = 1'b1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    addr   = '0;
    tick();
    chk_reset("rst");
    repeat (3) tick();

    // init with immediate ACMD41 success
    push_init(0);
    rst = 1'b0;
    wait_ready("init_ready");
    chk("init_div", status[7:5], 3'b001);
    chk("init_status", status, 8'h24);
    chk("init_busy", busy, 0);
    chk("init_left", exp_cmd.size(), 0);

    // single block read of 128 words
    rd_words = 128;
    rd_cnt   = 0;
    exp_op(8'h35, 48'h51_0000_0010_FF, 8'h00);
    addr   = 32'h0000_0010;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    addr   = 32'hFFFF_FFFF;
    chk("rd_busy", busy, 1);
    wait_ready("rd_ready");
    chk("rd_count", rd_cnt, 128);
    chk("rd_left", exp_rd.size(), 0);
    chk("rd_status", status, 8'h24);

    // simultaneous requests: read wins, write dropped
    rd_words = 4;
    base     = issued;
    exp_op(8'h35, 48'h51_0000_0055_FF, 8'h00);
    addr   = 32'h0000_0055;
    rd_req = 1'b1;
    wr_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    repeat (3) tick();
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    wait_ready("both_ready");
    repeat (20) tick();
    chk("both_issued", issued - base, 1);
    chk("both_left", exp_cmd.size(), 0);

    // write, then reset in the middle of it
    wr_words = 4;
    ack_cnt  = 0;
    wr_q.push_back(32'hDEAD_BEEF);
    exp_op(8'h2D, 48'h58_0000_0020_FF, 8'h00);
    addr   = 32'h0000_0020;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    n = 0;
    while (ack_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    chk("wr_ack_seen", ack_cnt, 1);
    tick();
    #3 rst = 1'b1;
    #1;
    chk_reset("midwr");
    repeat (10) tick();
    flush();

    // re-init from PWRUP with three busy ACMD41 replies
    push_init(3);
    rst = 1'b0;
    wait_ready("reinit_ready");
    chk("reinit_left", exp_cmd.size(), 0);

    // CMD0 never answered: eight attempts then error
    rst = 1'b1;
    repeat (10) tick();
    flush();
    exp_op(8'h87, 48'hFFFF_FFFF_FFFF, 8'hFF);
    for (int i = 0; i < 8; i++)
      exp_op(8'h85, 48'h40_0000_0000_95, 8'hFF);
    base = issued;
    rst  = 1'b0;
    n = 0;
    while (!error && n < 2000) begin
      tick();
      n++;
    end
    chk("err_flag", error, 1);
    chk("err_enable", enable, 0);
    chk("err_busy", busy, 0);
    chk("err_ready", ready, 0);
    chk("err_op", status[0], 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (50) tick();
    chk("err_issued", issued - base, 9);
    chk("err_left", exp_cmd.size(), 0);
    chk("err_sticky", error, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
